// File: rtl/period_meter_if.sv
// Result channel of period_meter: one measured period per transfer,
// plus the sticky missed flag that travels with the result stream.
interface period_meter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] period_out;
    logic             period_ovf;
    logic             period_valid;
    logic             period_ready;
    logic             missed;

    // valid/ready: a transfer happens on every rising clk edge where
    // period_valid and period_ready are both 1. While period_valid is 1
    // the producer holds period_out/period_ovf stable; the consumer may
    // drive period_ready at any time, independent of period_valid.
    modport master (
        output period_out,
        output period_ovf,
        output period_valid,
        output missed,
        input  period_ready
    );

    modport slave (
        input  period_out,
        input  period_ovf,
        input  period_valid,
        input  missed,
        output period_ready
    );
endinterface

// File: rtl/period_meter.sv
// Measures the interval between rising edges of an asynchronous input in clk
// cycles and hands each interval out over a one-deep valid/ready register.
module period_meter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sig_in,
    period_meter_if.master      result,
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_last_d;
    logic [WIDTH-1:0]       cnt;
    logic                   rise;
    logic                   capture;
    logic                   cnt_at_max;
    logic [WIDTH-1:0]       next_result;

    // Synchronizer and edge detector run regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync        <= '0;
            sync_last_d <= 1'b0;
        end else begin
            sync        <= {sync[SYNC_STAGES-2:0], sig_in};
            sync_last_d <= sync[SYNC_STAGES-1];
        end
    end

    assign rise        = sync[SYNC_STAGES-1] & ~sync_last_d;
    assign capture     = (state == MEASURE) & en & rise;
    assign cnt_at_max  = (cnt == CNT_MAX);
    // cnt counts the cycles after the previous edge, so the period is cnt+1.
    assign next_result = cnt_at_max ? CNT_MAX : cnt + 1'b1;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!en) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= ARM;
                    cnt   <= '0;
                end
                ARM: begin
                    cnt <= '0;
                    if (rise) state <= MEASURE;
                end
                MEASURE: begin
                    if (rise)             cnt <= '0;
                    else if (!cnt_at_max) cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // One-deep output register; a capture may replace a result being
    // accepted in the same cycle, otherwise an occupied register drops it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result.period_out   <= '0;
            result.period_ovf   <= 1'b0;
            result.period_valid <= 1'b0;
            result.missed       <= 1'b0;
        end else begin
            if (capture && (!result.period_valid || result.period_ready)) begin
                result.period_out   <= next_result;
                result.period_ovf   <= cnt_at_max;
                result.period_valid <= 1'b1;
            end else if (result.period_valid && result.period_ready) begin
                result.period_valid <= 1'b0;
            end

            if (!en)
                result.missed <= 1'b0;
            else if (capture && result.period_valid && !result.period_ready)
                result.missed <= 1'b1;
        end
    end
endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter (WIDTH=8 so saturation is reachable): table vectors,
// directed handshake/enable/reset sequences, and randomized square waves.
module tb_period_meter;
    localparam int W = 8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sig_in;
    logic [1:0] state_dbg;

    period_meter_if #(.WIDTH(W)) bus ();

    period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sig_in    (sig_in),
        .result    (bus),
        .state_dbg (state_dbg)
    );

    typedef struct {
        int         hi;
        int         lo;
        logic [7:0] exp_out;
        logic       exp_ovf;
    } vec_t;

    int           n_cmp = 0;
    int           n_err = 0;
    logic         mon_en = 1'b0;
    logic [W:0]   exp_q[$];
    vec_t         vecs[10];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wave(input int hi, input int lo);
        sig_in = 1'b1;
        repeat (hi) tick();
        sig_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic start_seq();
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (4) tick();
        en = 1'b1;
        tick();
    endtask

    task automatic end_seq();
        sig_in = 1'b1;
        repeat (5) tick();
    endtask

    task automatic drain();
        bus.period_ready = 1'b1;
        repeat (2) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [W:0] model(input int period);
        logic       ovf;
        logic [W-1:0] val;
        ovf = (period >= (1 << W));
        val = ovf ? W'((1 << W) - 1) : W'(period);
        return {ovf, val};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en && !rst && bus.period_valid && bus.period_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result: got out=%0d ovf=%0b with nothing expected",
                         bus.period_out, bus.period_ovf);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                if ({bus.period_ovf, bus.period_out} !== e) begin
                    n_err++;
                    $display("FAIL result: got out=%0d ovf=%0b expected out=%0d ovf=%0b",
                             bus.period_out, bus.period_ovf, e[W-1:0], e[W]);
                end
            end
        end
    end

    // ---------------- test ----------------
    initial begin
        vecs[0] = '{5,   5,   8'd10,  1'b0};
        vecs[1] = '{3,   3,   8'd6,   1'b0};
        vecs[2] = '{1,   1,   8'd2,   1'b0};
        vecs[3] = '{2,   1,   8'd3,   1'b0};
        vecs[4] = '{1,   2,   8'd3,   1'b0};
        vecs[5] = '{127, 127, 8'd254, 1'b0};
        vecs[6] = '{128, 127, 8'd255, 1'b0};
        vecs[7] = '{128, 128, 8'd255, 1'b1};
        vecs[8] = '{150, 150, 8'd255, 1'b1};
        vecs[9] = '{7,   9,   8'd16,  1'b0};

        en = 1'b0;
        sig_in = 1'b0;
        bus.period_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset_valid",  32'(bus.period_valid), 0);
        chk("reset_out",    32'(bus.period_out),   0);
        chk("reset_ovf",    32'(bus.period_ovf),   0);
        chk("reset_missed", 32'(bus.missed),       0);
        chk("reset_state",  32'(state_dbg),        0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Table vectors: each entry is one period; closed by the next rise.
        mon_en = 1'b1;
        start_seq();
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({vecs[i].exp_ovf, vecs[i].exp_out});
            wave(vecs[i].hi, vecs[i].lo);
        end
        end_seq();
        chk("table_drained", 32'(exp_q.size()), 0);
        chk("table_missed",  32'(bus.missed),   0);

        // Latency: second rise sampled at edge N -> valid after edge N+2.
        mon_en = 1'b0;
        start_seq();
        wave(5, 5);
        sig_in = 1'b1;
        tick();
        chk("lat_n0_valid", 32'(bus.period_valid), 0);
        tick();
        chk("lat_n1_valid", 32'(bus.period_valid), 0);
        tick();
        chk("lat_n2_valid", 32'(bus.period_valid), 1);
        chk("lat_n2_out",   32'(bus.period_out),   10);
        drain();

        // Backpressure: first value held, later captures dropped.
        bus.period_ready = 1'b0;
        start_seq();
        wave(3, 3);
        wave(3, 3);
        chk("bp_first_valid",  32'(bus.period_valid), 1);
        chk("bp_first_missed", 32'(bus.missed),       0);
        wave(3, 3);
        chk("bp_missed_set",   32'(bus.missed),       1);
        repeat (4) wave(3, 3);
        chk("bp_hold_valid",   32'(bus.period_valid), 1);
        chk("bp_hold_out",     32'(bus.period_out),   6);
        en = 1'b0;
        tick();
        chk("bp_en0_missed",   32'(bus.missed),       0);
        chk("bp_en0_valid",    32'(bus.period_valid), 1);
        bus.period_ready = 1'b1;
        tick();
        chk("bp_accept_valid", 32'(bus.period_valid), 0);

        // Enable raised while the synchronized input is already high.
        en = 1'b0;
        sig_in = 1'b1;
        repeat (5) tick();
        mon_en = 1'b1;
        en = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (3) tick();
        exp_q.push_back(model(7));
        wave(4, 3);
        end_seq();
        chk("arm_high_drained", 32'(exp_q.size()), 0);

        // Dropping en with a pending result.
        mon_en = 1'b0;
        bus.period_ready = 1'b0;
        start_seq();
        wave(4, 4);
        wave(4, 4);
        sig_in = 1'b1;
        repeat (3) tick();
        chk("en_drop_pending", 32'(bus.period_out), 8);
        en = 1'b0;
        repeat (3) wave(3, 3);
        chk("en_drop_valid", 32'(bus.period_valid), 1);
        chk("en_drop_out",   32'(bus.period_out),   8);
        bus.period_ready = 1'b1;
        tick();
        chk("en_drop_accept", 32'(bus.period_valid), 0);
        repeat (2) wave(3, 3);
        chk("en_drop_no_new", 32'(bus.period_valid), 0);

        // Asynchronous reset between edges with a pending result.
        bus.period_ready = 1'b0;
        start_seq();
        wave(4, 4);
        wave(4, 4);
        sig_in = 1'b1;
        repeat (3) tick();
        chk("rst_pre_valid", 32'(bus.period_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(bus.period_valid), 0);
        chk("rst_async_out",   32'(bus.period_out),   0);
        chk("rst_async_state", 32'(state_dbg),        0);
        tick();
        rst = 1'b0;
        bus.period_ready = 1'b1;
        mon_en = 1'b1;
        start_seq();
        exp_q.push_back(model(11));
        wave(5, 6);
        end_seq();
        chk("rst_after_drained", 32'(exp_q.size()), 0);

        // Randomized square waves against the interval model.
        start_seq();
        for (int i = 0; i < 40; i++) begin
            int hi;
            int lo;
            hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(100, 160)) : int'($urandom_range(1, 12));
            lo = int'($urandom_range(1, 12));
            exp_q.push_back(model(hi + lo));
            wave(hi, lo);
        end
        end_seq();
        chk("random_drained", 32'(exp_q.size()), 0);
        chk("random_missed",  32'(bus.missed),   0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/period_meter.md
# period_meter

Measures the period of an asynchronous square-wave input in clock cycles. Successive rising edges produce one WIDTH-bit period result each, delivered over a valid/ready handshake. It is the measurement side of the free-running cycle-count path in the DSP datapath: a counter produces time, and this block reads it back as intervals. Results feed the downstream frequency/rate logic.

## Interface
- WIDTH, 32: period counter and result width.
- SYNC_STAGES, 2: number of input synchronizer flops; legal range 2–4.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  measurement enable; level-sensitive.
- sig_in  in  1  asynchronous input signal to be measured.
- period_out  out  WIDTH  measured period in clk cycles.
- period_ovf  out  1  result saturated because the true period exceeded 2^WIDTH−1.
- period_valid  out  1  period_out and period_ovf hold a result.
- period_ready  in  1  consumer accepts the result.
- missed  out  1  sticky flag: a result was dropped because the output was occupied.

## Operation
- **Input path**
  - sig_in passes through SYNC_STAGES flops.
  - Edge detect: `edge` = sync_last & ~sync_last_d.
  - The synchronizer and edge detector run regardless of en.
- **States**
  - IDLE: en=0. The counter is held at 0.
  - ARM: en=1, waiting for the first edge. The counter is held at 0.
  - MEASURE: counting between edges.
- **Transitions**
  - IDLE→ARM when en=1.
  - ARM→MEASURE on `edge`. The counter is cleared to 0.
  - MEASURE stays in MEASURE on `edge` and captures a result.
  - Any state→IDLE when en=0. This takes priority over `edge`.
- **Counting in MEASURE**
  - Each cycle without `edge`, the counter increments and saturates at 2^WIDTH−1.
  - On `edge`, the result is sat(cnt+1). period_ovf is 1 when cnt == 2^WIDTH−1, otherwise 0. The counter is then cleared to 0.
- **Output register**
  - A result loads when `edge` occurs in MEASURE and either period_valid=0, or period_valid=1 and period_ready=1 in the same cycle.
  - Otherwise the result is discarded and missed is set.
  - period_valid clears on period_valid & period_ready when no new load occurs in that cycle.
  - period_out and period_ovf stay stable while period_valid=1.
- **en=0**
  - Does not clear a pending result; it can still be accepted.
  - Clears missed.
  - Rising edges in IDLE produce no result.
  - If en rises while sync_last is already high, no edge is generated. The first result comes from the second rising edge after arming.

## Timing
- **Reset values:** period_out=0, period_ovf=0, period_valid=0, missed=0, state=IDLE, counter=0, synchronizer flops=0.
- **Latency:** if sig_in is first sampled high at clock edge N, `edge` is captured at edge N+SYNC_STAGES. period_valid is high after that edge.
- **Period definition:** rising edges detected K cycles apart report period_out=K.
  - Minimum reportable value is 2, since an input high/low phase must each last at least 1 sampled cycle.
  - K=1 cannot occur after edge detection.
- **Back-to-back:** load and accept in the same cycle keeps period_valid=1 with the new value. There are no bubbles.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). The first result after reset release requires ARM plus two edges.
- **missed:** sets on the clock edge of the dropped capture. It stays set until en=0 or rst.

## Test plan
- **Basic period:** rst pulse, en=1, sig_in square wave with period 10 clk (5 high/5 low), period_ready=1 → first result 10 on the second rising edge, then 10 on every edge. period_ovf=0, missed=0.
- **Latency check:** SYNC_STAGES=2; sig_in rises just before edge N of the second period → period_valid high after edge N+2.
- **Backpressure:** period 6, period_ready=0 for 20 cycles → period_valid stays 1 and period_out stays at the first value 6. missed=1 after the second capture. Pulling en low clears missed.
- **Saturation:** WIDTH=8, sig_in period 300 → period_out=255, period_ovf=1. With period 255 → 255, period_ovf=0. With period 256 → 255, period_ovf=1.
- **Enable/arming:** en raised while sig_in is high → no result until two full rising edges have occurred. Dropping en mid-period with a pending result → the result is still accepted, and no new result appears while en=0.
- **Async reset mid-measurement:** assert rst between edges with period_valid=1 → all outputs 0 immediately without a clock. After release and en=1, the next correct period is reported.
